// File: rtl/axis_frame_arb.sv
// axis_frame_arb: two-port AXI-Stream frame arbiter with frame locking.
// A grant is held from the first beat of a frame until its tlast beat, so the
// beats of one frame are never interleaved with the other port. When both ports
// are waiting, the port that did not send the last frame is served first.
// The output is a single register stage; each grant costs one bubble cycle.
// Optional build macro: AXIS_FRAME_ARB_DROP_LAST_EN. When it is defined, the
// tlast beat of each frame is consumed (it ends the lock and counts the frame)
// but is not forwarded, so m_axis_tlast stays 0.
module axis_frame_arb #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arb_en,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                  s0_axis_tlast,
   input  logic                  s0_axis_tvalid,
   output logic                  s0_axis_tready,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                  s1_axis_tlast,
   input  logic                  s1_axis_tvalid,
   output logic                  s1_axis_tready,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   output logic [1:0]            grant,
   output logic [CNT_WIDTH-1:0]  frame_cnt0,
   output logic [CNT_WIDTH-1:0]  frame_cnt1
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                r_state;
   logic [1:0]            r_grant;
   logic                  r_prio;       // 0: port 0 wins a tie, 1: port 1 wins
   logic [CNT_WIDTH-1:0]  r_cnt0;
   logic [CNT_WIDTH-1:0]  r_cnt1;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic                  r_m_tlast;
   logic                  r_m_tvalid;

   logic                  w_out_free;
   logic                  w_acc0;
   logic                  w_acc1;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_acc_data;
   logic                  w_acc_last;
   logic                  w_load;

   // The output register can take a new beat when empty or being drained now.
   assign w_out_free     = !r_m_tvalid || m_axis_tready;
   assign s0_axis_tready = (r_state == LOCK0) && w_out_free;
   assign s1_axis_tready = (r_state == LOCK1) && w_out_free;

   assign w_acc0     = s0_axis_tvalid && s0_axis_tready;
   assign w_acc1     = s1_axis_tvalid && s1_axis_tready;
   assign w_accept   = w_acc0 || w_acc1;
   assign w_acc_data = w_acc1 ? s1_axis_tdata : s0_axis_tdata;
   assign w_acc_last = w_acc1 ? s1_axis_tlast : s0_axis_tlast;

`ifdef AXIS_FRAME_ARB_DROP_LAST_EN
   // The closing beat is swallowed; only the body of the frame reaches the output.
   assign w_load = w_accept && !w_acc_last;
`else
   assign w_load = w_accept;
`endif

   // Arbitration FSM: grant, tie-break pointer and per-port completed-frame counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 2'b00;
         r_prio  <= 1'b0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (arb_en && s0_axis_tvalid && (!s1_axis_tvalid || !r_prio)) begin
                  r_state <= LOCK0;
                  r_grant <= 2'b01;
               end else if (arb_en && s1_axis_tvalid) begin
                  r_state <= LOCK1;
                  r_grant <= 2'b10;
               end
            end
            LOCK0: begin
               if (w_acc0 && s0_axis_tlast) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_prio  <= 1'b1;
                  r_cnt0  <= r_cnt0 + 1'b1;
               end
            end
            LOCK1: begin
               if (w_acc1 && s1_axis_tlast) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_prio  <= 1'b0;
                  r_cnt1  <= r_cnt1 + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Output register: load on an accepted beat, otherwise empty once drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_tdata  <= '0;
         r_m_tlast  <= 1'b0;
         r_m_tvalid <= 1'b0;
      end else if (w_load) begin
         r_m_tdata  <= w_acc_data;
`ifdef AXIS_FRAME_ARB_DROP_LAST_EN
         r_m_tlast  <= 1'b0;
`else
         r_m_tlast  <= w_acc_last;
`endif
         r_m_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         r_m_tvalid <= 1'b0;
      end
   end

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tvalid = r_m_tvalid;
   assign grant         = r_grant;
   assign frame_cnt0    = r_cnt0;
   assign frame_cnt1    = r_cnt1;

endmodule

// File: tb/tb_axis_frame_arb.sv
// Testbench for axis_frame_arb: directed frames, expected output beats queued
// up front, a separate monitor pops and compares every output handshake.
// Honours AXIS_FRAME_ARB_DROP_LAST_EN when computing the expected beats.
module tb_axis_frame_arb;

   localparam int DW = 64;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arb_en = 1'b1;
   logic [DW-1:0] s0_tdata = '0;
   logic          s0_tlast = 1'b0;
   logic          s0_tvalid = 1'b0;
   logic          s0_tready;
   logic [DW-1:0] s1_tdata = '0;
   logic          s1_tlast = 1'b0;
   logic          s1_tvalid = 1'b0;
   logic          s1_tready;
   logic          m_tready = 1'b1;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic          m_tvalid;
   logic [1:0]    grant;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;

   axis_frame_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .arb_en(arb_en),
      .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast),
      .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast),
      .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
      .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
      .grant(grant), .frame_cnt0(cnt0), .frame_cnt1(cnt1)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   logic [DW:0] exp_q[$];        // {tlast, tdata}
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;
   logic mon_en = 1'b1;
   int lock0_cyc = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Queue the beats a frame should produce at the output.
   task automatic push_frame(input logic [DW-1:0] base, input int n);
`ifdef AXIS_FRAME_ARB_DROP_LAST_EN
      for (int i = 0; i < n - 1; i++) exp_q.push_back({1'b0, base + DW'(i)});
`else
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + DW'(i)});
`endif
   endtask

   task automatic send_frame(input int port, input logic [DW-1:0] base, input int n);
      logic hs;
      for (int i = 0; i < n; i++) begin
         if (port == 1) begin
            s1_tdata = base + DW'(i); s1_tlast = (i == n - 1); s1_tvalid = 1'b1;
         end else begin
            s0_tdata = base + DW'(i); s0_tlast = (i == n - 1); s0_tvalid = 1'b1;
         end
         hs = 1'b0;
         for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = (port == 1) ? (s1_tvalid && s1_tready) : (s0_tvalid && s0_tready);
         end
         if (!hs) begin
            errors++;
            $display("FAIL handshake_timeout port%0d: got no tready, expected tready within 200 cycles", port);
            break;
         end
         check($sformatf("grant_p%0d_beat%0d", port, i), DW'(grant), (port == 1) ? DW'(2) : DW'(1));
         @(posedge clk); #1;
      end
      if (port == 1) begin
         s1_tvalid = 1'b0; s1_tlast = 1'b0;
         exp_cnt1++;
         check("frame_cnt1", DW'(cnt1), DW'(exp_cnt1 % (1 << CW)));
      end else begin
         s0_tvalid = 1'b0; s0_tlast = 1'b0;
         exp_cnt0++;
         check("frame_cnt0", DW'(cnt0), DW'(exp_cnt0 % (1 << CW)));
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt0 = 0; exp_cnt1 = 0;
   endtask

   // Monitor: compare each output handshake against the queue, check holds under backpressure.
   initial begin
      logic          prev_hold;
      logic [DW-1:0] prev_data;
      logic [DW:0]   e;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (prev_hold) begin
               check("hold_tdata", m_tdata, prev_data);
               check("hold_tvalid", DW'(m_tvalid), DW'(1));
            end
            if (m_tvalid && !m_tready)
               check("tready_while_full", DW'({s1_tready, s0_tready}), DW'(0));
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  vectors++; errors++;
                  $display("FAIL unexpected_beat: got 0x%0h last=%0d, expected no beat", m_tdata, m_tlast);
               end else begin
                  e = exp_q.pop_front();
                  check("out_tdata", m_tdata, e[DW-1:0]);
                  check("out_tlast", DW'(m_tlast), DW'(e[DW]));
               end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   // Count cycles spent locked to port 0.
   initial forever begin
      @(negedge clk);
      if (grant == 2'b01) lock0_cyc++;
   end

   initial begin
      int base_cyc;
      int t;
      int beats;

      // Reset state
      #2;
      check("rst_grant", DW'(grant), DW'(0));
      check("rst_tvalid", DW'(m_tvalid), DW'(0));
      check("rst_tlast", DW'(m_tlast), DW'(0));
      check("rst_tdata", m_tdata, DW'(0));
      check("rst_cnt", DW'({cnt1, cnt0}), DW'(0));
      check("rst_tready", DW'({s1_tready, s0_tready}), DW'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Single port 4-beat frame
      push_frame(DW'('h10), 4);
      send_frame(0, DW'('h10), 4);
      check("grant_after_frame", DW'(grant), DW'(0));
      repeat (3) @(posedge clk); #1;

      // Contention from reset: expect port0, port1, port0
      pulse_reset();
      push_frame(DW'('h20), 3);
      push_frame(DW'('h30), 3);
      push_frame(DW'('h28), 3);
      fork
         begin send_frame(0, DW'('h20), 3); send_frame(0, DW'('h28), 3); end
         send_frame(1, DW'('h30), 3);
      join
      repeat (3) @(posedge clk); #1;

      // Backpressure: downstream stalls 5 cycles mid-frame
      push_frame(DW'('h40), 6);
      fork
         send_frame(0, DW'('h40), 6);
         begin
            repeat (3) @(posedge clk); #1;
            m_tready = 1'b0;
            repeat (5) @(posedge clk); #1;
            m_tready = 1'b1;
         end
      join
      repeat (3) @(posedge clk); #1;

      // arb_en low: s1 waiting in IDLE is never granted
      arb_en = 1'b0;
      s1_tdata = DW'('h60); s1_tlast = 1'b0; s1_tvalid = 1'b1;
      repeat (8) @(posedge clk); #1;
      check("arb_dis_grant", DW'(grant), DW'(0));
      check("arb_dis_tready", DW'(s1_tready), DW'(0));
      arb_en = 1'b1;
      push_frame(DW'('h60), 2);
      send_frame(1, DW'('h60), 2);

      // arb_en dropped mid-frame: the frame still completes
      push_frame(DW'('h70), 4);
      fork
         send_frame(0, DW'('h70), 4);
         begin
            t = 0;
            while (grant != 2'b01 && t < 100) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
            arb_en = 1'b0;
         end
      join
      repeat (2) @(posedge clk); #1;
      check("arb_drop_idle", DW'(grant), DW'(0));
      arb_en = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("queue_drained", DW'(exp_q.size()), DW'(0));

      // Reset on beat 2 of a 4-beat frame
      mon_en = 1'b0;
      s0_tdata = DW'('h50); s0_tlast = 1'b0; s0_tvalid = 1'b1;
      beats = 0;
      for (int i = 0; i < 50 && beats < 2; i++) begin
         @(negedge clk);
         if (s0_tvalid && s0_tready) begin
            @(posedge clk); #1;
            beats++;
            s0_tdata = s0_tdata + 1;
         end
      end
      check("pre_rst_tvalid", DW'(m_tvalid), DW'(1));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tvalid", DW'(m_tvalid), DW'(0));
      check("async_rst_cnt0", DW'(cnt0), DW'(0));
      check("async_rst_cnt1", DW'(cnt1), DW'(0));
      check("async_rst_grant", DW'(grant), DW'(0));
      s0_tvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt0 = 0; exp_cnt1 = 0;
      exp_q.delete();
      repeat (3) @(posedge clk); #1;
      check("post_rst_grant", DW'(grant), DW'(0));
      check("post_rst_tvalid", DW'(m_tvalid), DW'(0));
      mon_en = 1'b1;

      // Single-beat frames: one LOCK cycle each, counter wraps past all-ones
      base_cyc = lock0_cyc;
      push_frame(DW'('h80), 1);
      send_frame(0, DW'('h80), 1);
      @(posedge clk); #1;
      check("single_beat_lock_cycles", DW'(lock0_cyc - base_cyc), DW'(1));
      for (int i = 1; i < 9; i++) begin
         push_frame(DW'('h80 + i), 1);
         send_frame(0, DW'('h80 + i), 1);
      end
      check("cnt0_wrapped", DW'(cnt0), DW'(1));
      repeat (4) @(posedge clk); #1;
      check("final_queue_empty", DW'(exp_q.size()), DW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
